// File: rtl/max_pool_stream.sv
// max_pool_stream
//   Streaming 2x2 / stride-2 signed max-pooling over a raster-scan feature map.
//   Each accepted beat carries one pixel in raster order. Pixels in even
//   columns are held. In odd columns the horizontal pair maximum is formed.
//   On even rows that pair maximum is parked in a half-line buffer. On odd rows
//   it is merged with the parked value, and the pooled pixel is registered.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   enable     frame enable; high in IDLE starts a frame, low in RUN aborts it
//   in_valid   input pixel valid
//   in_ready   block accepts a pixel (only while running and enabled)
//   in_data    signed input pixel, raster order
//   out_valid  one-cycle strobe marking a new pooled pixel on out_data
//   out_data   signed max of the 2x2 window, held between strobes
//   done       one-cycle pulse coincident with the last strobe of a frame
module max_pool_stream #(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 8,
  parameter int IMG_H  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_data,
  output logic                     out_valid,
  output logic signed [DATA_W-1:0] out_data,
  output logic                     done
);

  localparam int COL_W = (IMG_W > 2) ? $clog2(IMG_W) : 1;
  localparam int ROW_W = (IMG_H > 2) ? $clog2(IMG_H) : 1;
  localparam int LB_N  = (IMG_W >= 2) ? IMG_W / 2 : 1;
  localparam int LB_W  = (LB_N > 1) ? $clog2(LB_N) : 1;

  if ((IMG_W < 2) || ((IMG_W % 2) != 0)) begin : g_bad_img_w
    $error("max_pool_stream: IMG_W must be even and >= 2");
  end
  if ((IMG_H < 2) || ((IMG_H % 2) != 0)) begin : g_bad_img_h
    $error("max_pool_stream: IMG_H must be even and >= 2");
  end

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_t;

  state_t                   state;
  state_t                   state_next;
  logic [COL_W-1:0]         col;
  logic [ROW_W-1:0]         row;
  logic signed [DATA_W-1:0] hold;
  logic signed [DATA_W-1:0] pmax;
  logic signed [DATA_W-1:0] lb_val;
  logic signed [DATA_W-1:0] win_max;
  logic signed [DATA_W-1:0] linebuf [LB_N];
  logic [LB_W-1:0]          pair_idx;
  logic                     accept;
  logic                     col_last;
  logic                     row_last;

  // Handshake is gated by enable as well as state. A cycle in which enable has
  // already dropped can never consume a pixel.
  assign in_ready = (state == ST_RUN) && enable;
  assign accept   = in_valid && in_ready;
  assign done     = (state == ST_DONE);

  assign col_last = (col == COL_W'(IMG_W - 1));
  assign row_last = (row == ROW_W'(IMG_H - 1));
  assign pair_idx = LB_W'(col >> 1);

  // Signed comparisons at full width. The most negative code needs no special
  // handling.
  assign pmax    = (in_data > hold) ? in_data : hold;
  assign lb_val  = linebuf[pair_idx];
  assign win_max = (lb_val > pmax) ? lb_val : pmax;

  // The state register alone carries the frame sequencing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // An abort takes priority over completion. DONE always lasts exactly one
  // cycle, so done and the final strobe coincide.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (enable) state_next = ST_RUN;
      ST_RUN: begin
        if (!enable) begin
          state_next = ST_IDLE;
        end else if (accept && col_last && row_last) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // The raster position advances only on accepted beats. Outside an active,
  // enabled RUN it is held at the origin, so every new frame starts at (0,0).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col <= '0;
      row <= '0;
    end else if ((state != ST_RUN) || !enable) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      if (col_last) begin
        col <= '0;
        row <= row_last ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  // Even columns are held for the pair maximum. An odd column on an odd row
  // closes a 2x2 window, and that window's result is registered for
  // one-cycle latency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      hold      <= '0;
    end else begin
      out_valid <= 1'b0;
      if (accept) begin
        if (!col[0]) begin
          hold <= in_data;
        end else if (row[0]) begin
          out_data  <= win_max;
          out_valid <= 1'b1;
        end
      end
    end
  end

  // The half-line buffer is plain registers without reset. Every entry is
  // rewritten on an even row before it is read on the next odd row.
  always_ff @(posedge clk) begin
    if (accept && col[0] && !row[0]) begin
      linebuf[pair_idx] <= pmax;
    end
  end

endmodule

// File: tb/tb_max_pool_stream.sv
// tb_max_pool_stream
//   Self-checking bench for max_pool_stream. Instance A is 4x4 and runs the
//   directed frames. Instance B is 8x2 and runs random frames. For every
//   accepted window-closing pixel, the expected pooled value is computed
//   directly from the stored frame as the max of its four pixels. That value
//   is queued with the cycle it must appear in. A negedge compare process
//   checks out_valid, out_data and done against the queue on every cycle.
module tb_max_pool_stream;

  localparam int DW   = 8;
  localparam int WA   = 4;
  localparam int HA   = 4;
  localparam int WB   = 8;
  localparam int HB   = 2;
  localparam int NPIX = 16;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 enA = 1'b0;
  logic                 validA = 1'b0;
  logic                 readyA;
  logic signed [DW-1:0] dataA = '0;
  logic                 outValidA;
  logic signed [DW-1:0] outDataA;
  logic                 doneA;
  logic                 enB = 1'b0;
  logic                 validB = 1'b0;
  logic                 readyB;
  logic signed [DW-1:0] dataB = '0;
  logic                 outValidB;
  logic signed [DW-1:0] outDataB;
  logic                 doneB;

  max_pool_stream #(.DATA_W(DW), .IMG_W(WA), .IMG_H(HA)) dutA (
    .clk(clk), .rst(rst), .enable(enA), .in_valid(validA), .in_ready(readyA),
    .in_data(dataA), .out_valid(outValidA), .out_data(outDataA), .done(doneA)
  );

  max_pool_stream #(.DATA_W(DW), .IMG_W(WB), .IMG_H(HB)) dutB (
    .clk(clk), .rst(rst), .enable(enB), .in_valid(validB), .in_ready(readyB),
    .in_data(dataB), .out_valid(outValidB), .out_data(outDataB), .done(doneB)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cycle;
    int value;
    bit last;
  } expect_t;

  expect_t expA[$];
  expect_t expB[$];
  int      pix[2][NPIX];
  int      lastOut[2];
  int      outCount[2];
  int      doneCount[2];
  int      checks = 0;
  int      errors = 0;
  int      cyc = 0;

  // A free-running cycle index lets expectations name the exact cycle of a strobe.
  always @(posedge clk) cyc <= cyc + 1;

  // Central comparison: counts every check and reports a mismatch on one line.
  task automatic expectEq(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Per-cycle output check for one instance. During reset everything must read
  // zero and pending expectations are discarded. Otherwise a strobe is required
  // exactly when an expectation falls due, and out_data must hold the last result.
  task automatic checkOutput(input int sel, input logic v, input logic signed [DW-1:0] d,
                             input logic dn);
    string   tag;
    expect_t e;
    bit      due;
    bit      wantDone;
    tag = (sel == 0) ? "A" : "B";
    due = 1'b0;
    wantDone = 1'b0;
    if (rst) begin
      if (sel == 0) expA.delete();
      else expB.delete();
      lastOut[sel] = 0;
      expectEq({tag, " reset out_valid"}, int'(v), 0);
      expectEq({tag, " reset out_data"}, int'(d), 0);
      expectEq({tag, " reset done"}, int'(dn), 0);
      return;
    end
    if (sel == 0) begin
      if (expA.size() > 0 && expA[0].cycle == cyc) begin
        e = expA.pop_front();
        due = 1'b1;
      end
    end else begin
      if (expB.size() > 0 && expB[0].cycle == cyc) begin
        e = expB.pop_front();
        due = 1'b1;
      end
    end
    if (due) begin
      lastOut[sel] = e.value;
      wantDone = e.last;
    end
    expectEq({tag, " out_valid"}, int'(v), int'(due));
    expectEq({tag, " out_data"}, int'(d), lastOut[sel]);
    expectEq({tag, " done"}, int'(dn), int'(wantDone));
    if (v) outCount[sel]++;
    if (dn) doneCount[sel]++;
  endtask

  // Sampled on the falling edge, well away from the active edge.
  always @(negedge clk) begin
    checkOutput(0, outValidA, outDataA, doneA);
    checkOutput(1, outValidB, outDataB, doneB);
  end

  task automatic setIn(input int sel, input bit v, input int d);
    if (sel == 0) begin
      validA = v;
      dataA = DW'(d);
    end else begin
      validB = v;
      dataB = DW'(d);
    end
  endtask

  task automatic setEn(input int sel, input bit e);
    if (sel == 0) enA = e;
    else enB = e;
  endtask

  function automatic bit getReady(input int sel);
    return (sel == 0) ? readyA : readyB;
  endfunction

  function automatic int widthOf(input int sel);
    return (sel == 0) ? WA : WB;
  endfunction

  // Reference: the pooled value for the window closed by pixel idx is the
  // largest of its four pixels in the stored frame.
  function automatic int poolMax(input int sel, input int idx);
    int w;
    int r;
    int c;
    int m;
    int v[4];
    w = widthOf(sel);
    r = idx / w;
    c = idx % w;
    v[0] = pix[sel][(r - 1) * w + c - 1];
    v[1] = pix[sel][(r - 1) * w + c];
    v[2] = pix[sel][r * w + c - 1];
    v[3] = pix[sel][r * w + c];
    m = v[0];
    for (int i = 1; i < 4; i++) if (v[i] > m) m = v[i];
    return m;
  endfunction

  task automatic clearCounts(input int sel);
    outCount[sel] = 0;
    doneCount[sel] = 0;
  endtask

  task automatic loadRamp(input int sel);
    for (int i = 0; i < NPIX; i++) pix[sel][i] = i;
  endtask

  task automatic loadRandom(input int sel);
    for (int i = 0; i < NPIX; i++) pix[sel][i] = int'($urandom_range(0, 255)) - 128;
  endtask

  // Drives one frame from pix[sel]. gapPct sets the chance of an idle beat.
  // stopAt >= 0 ends the frame once that many pixels are accepted: by dropping
  // enable, or by pulsing reset when useReset is set. keepEn leaves enable high
  // afterwards for back-to-back frames.
  task automatic applyStimulus(input int sel, input int gapPct, input int stopAt,
                               input bit useReset, input bit keepEn);
    int      n;
    int      w;
    int      idx;
    int      budget;
    bit      v;
    expect_t e;
    w = widthOf(sel);
    n = NPIX;
    idx = 0;
    budget = 0;
    @(negedge clk);
    #1;
    setEn(sel, 1'b1);
    while (idx < n) begin
      @(negedge clk);
      #1;
      if (idx == stopAt) begin
        setIn(sel, 1'b0, 0);
        setEn(sel, 1'b0);
        if (useReset) begin
          rst = 1'b1;
          repeat (3) @(negedge clk);
          #1;
          rst = 1'b0;
        end
        return;
      end
      v = ($urandom_range(0, 99) >= gapPct);
      setIn(sel, v, pix[sel][idx]);
      #1;
      if (v && getReady(sel)) begin
        if (((idx / w) % 2 == 1) && ((idx % w) % 2 == 1)) begin
          e.cycle = cyc + 1;
          e.value = poolMax(sel, idx);
          e.last = (idx == n - 1);
          if (sel == 0) expA.push_back(e);
          else expB.push_back(e);
        end
        idx++;
      end
      budget++;
      if (budget > 2000) begin
        checks++;
        errors++;
        $display("[TB] FAIL handshake timeout: got %0d accepted, expected %0d", idx, n);
        break;
      end
    end
    @(negedge clk);
    #1;
    setIn(sel, 1'b0, 0);
    if (!keepEn) setEn(sel, 1'b0);
  endtask

  // Waits a bounded time for outstanding strobes, then checks frame totals.
  task automatic drainAndCount(input int sel, input string name, input int wantOuts,
                               input int wantDone);
    int n;
    n = 0;
    while (n < 20 && ((sel == 0) ? expA.size() : expB.size()) > 0) begin
      @(negedge clk);
      #1;
      n++;
    end
    expectEq({name, " pending strobes"}, (sel == 0) ? expA.size() : expB.size(), 0);
    repeat (3) @(negedge clk);
    #1;
    expectEq({name, " output count"}, outCount[sel], wantOuts);
    expectEq({name, " done pulses"}, doneCount[sel], wantDone);
  endtask

  initial begin
    $display("[TB] max_pool_stream bench starting");
    repeat (2) @(negedge clk);
    #1;
    expectEq("A reset in_ready", int'(readyA), 0);
    expectEq("B reset in_ready", int'(readyB), 0);
    rst = 1'b0;

    // Ramp 0..15: windows close on pixels 5, 7, 13 and 15.
    loadRamp(0);
    expectEq("model ramp w0", poolMax(0, 5), 5);
    expectEq("model ramp w1", poolMax(0, 7), 7);
    expectEq("model ramp w2", poolMax(0, 13), 13);
    expectEq("model ramp w3", poolMax(0, 15), 15);
    clearCounts(0);
    applyStimulus(0, 0, -1, 1'b0, 1'b0);
    drainAndCount(0, "ramp", 4, 1);

    // All-negative rows -1..-16.
    for (int i = 0; i < NPIX; i++) pix[0][i] = -(i + 1);
    expectEq("model neg w0", poolMax(0, 5), -1);
    expectEq("model neg w1", poolMax(0, 7), -3);
    expectEq("model neg w2", poolMax(0, 13), -9);
    expectEq("model neg w3", poolMax(0, 15), -11);
    clearCounts(0);
    applyStimulus(0, 0, -1, 1'b0, 1'b0);
    drainAndCount(0, "negative", 4, 1);

    // Every pixel at the most negative code.
    for (int i = 0; i < NPIX; i++) pix[0][i] = -128;
    expectEq("model min w3", poolMax(0, 15), -128);
    clearCounts(0);
    applyStimulus(0, 0, -1, 1'b0, 1'b0);
    drainAndCount(0, "most-negative", 4, 1);

    // Ramp with roughly half the beats idle.
    loadRamp(0);
    clearCounts(0);
    applyStimulus(0, 50, -1, 1'b0, 1'b0);
    drainAndCount(0, "ramp gaps", 4, 1);

    // Abort before the first window closes, then a clean frame.
    clearCounts(0);
    applyStimulus(0, 0, 5, 1'b0, 1'b0);
    drainAndCount(0, "abort", 0, 0);
    clearCounts(0);
    applyStimulus(0, 0, -1, 1'b0, 1'b0);
    drainAndCount(0, "after abort", 4, 1);

    // Reset early in row 3. Only the two row-1 windows have completed.
    clearCounts(0);
    applyStimulus(0, 0, 13, 1'b1, 1'b0);
    drainAndCount(0, "reset mid-frame", 2, 0);
    clearCounts(0);
    applyStimulus(0, 0, -1, 1'b0, 1'b0);
    drainAndCount(0, "after reset", 4, 1);

    // Two random frames back to back with enable held high throughout.
    clearCounts(0);
    loadRandom(0);
    applyStimulus(0, 30, -1, 1'b0, 1'b1);
    loadRandom(0);
    applyStimulus(0, 30, -1, 1'b0, 1'b0);
    drainAndCount(0, "back-to-back", 8, 2);

    // 8x2 instance: one line pair per frame, four outputs each.
    for (int f = 0; f < 3; f++) begin
      clearCounts(1);
      loadRandom(1);
      applyStimulus(1, 40, -1, 1'b0, 1'b0);
      drainAndCount(1, "8x2 random", 4, 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
